// File: rtl/rat_io_pkg.sv
// Shared RAT MCU port map: default port IDs, sizing limits and the write-decode select type.
package rat_io_pkg;

  localparam logic [7:0] PortSwitches  = 8'h20;
  localparam logic [7:0] PortRand      = 8'h21;
  localparam logic [7:0] PortLeds      = 8'h40;
  localparam logic [7:0] PortKeyboard  = 8'h44;
  localparam logic [7:0] PortSsegLo    = 8'h81;
  localparam logic [7:0] PortSsegHi    = 8'h82;
  localparam logic [7:0] PortVgaHaddr  = 8'h90;
  localparam logic [7:0] PortVgaLaddr  = 8'h91;
  localparam logic [7:0] PortVgaColor  = 8'h92;
  localparam logic [7:0] PortVgaRead   = 8'h93;
  localparam logic [7:0] PortIrqStat   = 8'hF0;
  localparam logic [7:0] PortIrqMask   = 8'hF1;
  localparam logic [7:0] PortIrqAck    = 8'hF2;

  localparam int unsigned MaxOut = 16;
  localparam int unsigned MaxIn  = 16;
  localparam int unsigned MaxIrq = 8;

  typedef enum logic [1:0] {WrNone, WrOut, WrMask, WrAck} wr_sel_e;

  function automatic bit range_hit(int unsigned id, int unsigned base, int unsigned n);
    return (id >= base) && (id < base + n);
  endfunction

endpackage

// File: rtl/rat_irq_ctrl.sv
// Interrupt controller: rising-edge capture into pending, mask, W1C acknowledge, registered INTR.
module rat_irq_ctrl #(
  parameter int unsigned N_IRQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] src_i,
  input  logic             mask_we_i,
  input  logic             ack_we_i,
  input  logic [N_IRQ-1:0] wdata_i,
  output logic [N_IRQ-1:0] mask_o,
  output logic [N_IRQ-1:0] pend_o,
  output logic             intr_o
);

  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] mask_q;
  logic             intr_q;

  // A new edge overrides a same-cycle acknowledge so no event is lost.
  always_comb begin
    pend_d = pend_q;
    if (ack_we_i) pend_d = pend_d & ~wdata_i;
    pend_d = pend_d | (src_i & ~src_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q  <= src_i;
      pend_q <= '0;
      mask_q <= '0;
      intr_q <= 1'b0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
      if (mask_we_i) mask_q <= wdata_i;
      intr_q <= |(pend_q & mask_q);
    end
  end

  assign mask_o = mask_q;
  assign pend_o = pend_q;
  assign intr_o = intr_q;

endmodule

// File: rtl/rat_io_hub.sv
// RAT MCU port-bus hub: strobe edge detect, write decode, output registers, read mux, IRQ block.
module rat_io_hub
  import rat_io_pkg::*;
#(
  parameter int unsigned N_OUT       = 8,
  parameter int unsigned N_IN        = 4,
  parameter int unsigned N_IRQ       = 4,
  parameter logic [7:0]  OUT_BASE    = 8'h80,
  parameter logic [7:0]  IN_BASE     = PortSwitches,
  parameter logic [7:0]  IRQ_STAT_ID = PortIrqStat,
  parameter logic [7:0]  IRQ_MASK_ID = PortIrqMask,
  parameter logic [7:0]  IRQ_ACK_ID  = PortIrqAck
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [7:0]           PORT_ID,
  input  logic [7:0]           OUT_PORT,
  input  logic                 IO_STRB,
  output logic [7:0]           IN_PORT,
  input  logic [8*N_IN-1:0]    IN_DATA,
  input  logic [N_IRQ-1:0]     IRQ_SRC,
  output logic [8*N_OUT-1:0]   OUT_REGS,
  output logic [N_OUT-1:0]     WR_PULSE,
  output logic                 INTR
);

  localparam int unsigned OutB = int'(OUT_BASE);
  localparam int unsigned InB  = int'(IN_BASE);
  localparam int unsigned StId = int'(IRQ_STAT_ID);
  localparam int unsigned MkId = int'(IRQ_MASK_ID);
  localparam int unsigned AkId = int'(IRQ_ACK_ID);

  localparam bit ParamBad = (N_OUT < 1) || (N_OUT > MaxOut) || (N_IN < 1) || (N_IN > MaxIn) ||
                            (N_IRQ < 1) || (N_IRQ > MaxIrq) ||
                            (OutB + N_OUT > 256) || (InB + N_IN > 256);

  localparam bit MapBad = ((OutB < InB + N_IN) && (InB < OutB + N_OUT)) ||
                          range_hit(StId, OutB, N_OUT) || range_hit(StId, InB, N_IN) ||
                          range_hit(MkId, OutB, N_OUT) || range_hit(MkId, InB, N_IN) ||
                          range_hit(AkId, OutB, N_OUT) || range_hit(AkId, InB, N_IN) ||
                          (StId == MkId) || (StId == AkId) || (MkId == AkId);

  if (ParamBad) begin : g_param_err
    $error("rat_io_hub: parameter out of range");
  end
  if (MapBad) begin : g_map_err
    $error("rat_io_hub: overlapping port address ranges");
  end

  localparam logic [7:0] NOut8 = 8'(N_OUT);
  localparam logic [7:0] NIn8  = 8'(N_IN);

  logic                    strb_q;
  logic                    wr_evt;
  logic [N_OUT-1:0][7:0]   out_q;
  logic [N_OUT-1:0]        pulse_q;
  logic [7:0]              out_off, in_off;
  logic                    out_hit, in_hit;
  wr_sel_e                 wr_sel;
  logic [N_IRQ-1:0]        irq_mask, irq_pend;
  logic [7:0]              rd_data;

  assign wr_evt  = IO_STRB & ~strb_q;
  assign out_off = PORT_ID - OUT_BASE;
  assign in_off  = PORT_ID - IN_BASE;
  assign out_hit = (PORT_ID >= OUT_BASE) && (out_off < NOut8);
  assign in_hit  = (PORT_ID >= IN_BASE) && (in_off < NIn8);

  always_comb begin
    wr_sel = WrNone;
    if (out_hit)                     wr_sel = WrOut;
    else if (PORT_ID == IRQ_MASK_ID) wr_sel = WrMask;
    else if (PORT_ID == IRQ_ACK_ID)  wr_sel = WrAck;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      strb_q  <= IO_STRB;
      out_q   <= '0;
      pulse_q <= '0;
    end else begin
      strb_q  <= IO_STRB;
      pulse_q <= '0;
      if (wr_evt && (wr_sel == WrOut)) begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
          if (out_off == 8'(k)) begin
            out_q[k]   <= OUT_PORT;
            pulse_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  rat_irq_ctrl #(
    .N_IRQ (N_IRQ)
  ) u_irq (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .src_i     (IRQ_SRC),
    .mask_we_i (wr_evt && (wr_sel == WrMask)),
    .ack_we_i  (wr_evt && (wr_sel == WrAck)),
    .wdata_i   (OUT_PORT[N_IRQ-1:0]),
    .mask_o    (irq_mask),
    .pend_o    (irq_pend),
    .intr_o    (INTR)
  );

  always_comb begin
    rd_data = 8'h00;
    if (in_hit) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (in_off == 8'(k)) rd_data = IN_DATA[8*k +: 8];
      end
    end else if (PORT_ID == IRQ_STAT_ID) begin
      for (int unsigned i = 0; i < N_IRQ; i++) rd_data[i] = irq_pend[i] & irq_mask[i];
    end else if (PORT_ID == IRQ_MASK_ID) begin
      for (int unsigned i = 0; i < N_IRQ; i++) rd_data[i] = irq_mask[i];
    end
  end

  assign IN_PORT  = rd_data;
  assign OUT_REGS = out_q;
  assign WR_PULSE = pulse_q;

endmodule

// File: tb/tb_rat_io_hub.sv
// Directed bench for rat_io_hub with default parameters (8 out, 4 in, 4 IRQ).
module tb_rat_io_hub;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic [31:0] IN_DATA;
  logic [3:0]  IRQ_SRC;
  logic [63:0] OUT_REGS;
  logic [7:0]  WR_PULSE;
  logic        INTR;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  rat_io_hub dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .IN_PORT  (IN_PORT),
    .IN_DATA  (IN_DATA),
    .IRQ_SRC  (IRQ_SRC),
    .OUT_REGS (OUT_REGS),
    .WR_PULSE (WR_PULSE),
    .INTR     (INTR)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One write event; returns just after the sampling edge with the strobe dropped.
  task automatic port_wr(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
    PORT_ID = id;
    #1;
    chk(tag, 64'(IN_PORT), 64'(exp));
  endtask

  initial begin
    RST_N    = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    IN_DATA  = 32'h4433_7E11;
    IRQ_SRC  = 4'b0000;
    tick();
    tick();
    RST_N = 1'b1;
    tick();

    chk("rst_out_regs", OUT_REGS, 64'h0);
    chk("rst_wr_pulse", 64'(WR_PULSE), 64'h0);
    chk("rst_intr", 64'(INTR), 64'h0);
    rd("rst_rd_55", 8'h55, 8'h00);

    // Strobe held 4 cycles writes once
    PORT_ID  = 8'h82;
    OUT_PORT = 8'hA5;
    IO_STRB  = 1'b1;
    tick();
    chk("wr1_reg2", 64'(OUT_REGS[23:16]), 64'hA5);
    chk("wr1_pulse", 64'(WR_PULSE), 64'h04);
    tick();
    chk("wr1_pulse_fall", 64'(WR_PULSE), 64'h0);
    tick();
    tick();
    chk("wr1_hold_nopulse", 64'(WR_PULSE), 64'h0);
    IO_STRB = 1'b0;
    tick();
    port_wr(8'h82, 8'h3C);
    chk("wr2_reg2", 64'(OUT_REGS[23:16]), 64'h3C);
    chk("wr2_pulse", 64'(WR_PULSE), 64'h04);
    chk("wr2_regs_all", OUT_REGS, 64'h0000_0000_003C_0000);
    tick();
    chk("wr2_pulse_fall", 64'(WR_PULSE), 64'h0);

    rd("rd_ch1", 8'h21, 8'h7E);
    rd("rd_ch3", 8'h23, 8'h44);
    rd("rd_oob_24", 8'h24, 8'h00);
    IN_DATA = 32'h4433_9911;
    rd("rd_ch1_live", 8'h21, 8'h99);

    // Masked interrupt path and acknowledge
    port_wr(8'hF1, 8'h05);
    tick();
    IRQ_SRC = 4'b0100;
    tick();
    chk("irq2_intr_t", 64'(INTR), 64'h0);
    tick();
    chk("irq2_intr_t1", 64'(INTR), 64'h1);
    rd("irq2_stat", 8'hF0, 8'h04);
    rd("irq2_mask", 8'hF1, 8'h05);
    port_wr(8'hF2, 8'h04);
    chk("ack2_intr_t", 64'(INTR), 64'h1);
    tick();
    chk("ack2_intr_t1", 64'(INTR), 64'h0);
    rd("ack2_stat", 8'hF0, 8'h00);

    // Pending while masked, then unmask
    port_wr(8'hF1, 8'h00);
    tick();
    IRQ_SRC = 4'b0110;
    tick();
    tick();
    chk("irq1_masked_intr", 64'(INTR), 64'h0);
    rd("irq1_masked_stat", 8'hF0, 8'h00);
    port_wr(8'hF1, 8'h02);
    chk("unmask_intr_t", 64'(INTR), 64'h0);
    tick();
    chk("unmask_intr_t1", 64'(INTR), 64'h1);
    rd("unmask_stat", 8'hF0, 8'h02);

    // Mask to 0 while pending: INTR drops, pending kept
    port_wr(8'hF1, 8'h00);
    chk("mask0_intr_t", 64'(INTR), 64'h1);
    tick();
    chk("mask0_intr_t1", 64'(INTR), 64'h0);
    port_wr(8'hF1, 8'h02);
    tick();
    chk("remask_intr", 64'(INTR), 64'h1);

    // Set wins over same-cycle acknowledge
    port_wr(8'hF1, 8'h01);
    tick();
    chk("m01_intr", 64'(INTR), 64'h0);
    PORT_ID  = 8'hF2;
    OUT_PORT = 8'h01;
    IO_STRB  = 1'b1;
    IRQ_SRC  = 4'b0111;
    tick();
    IO_STRB = 1'b0;
    tick();
    chk("setwin_intr", 64'(INTR), 64'h1);
    rd("setwin_stat", 8'hF0, 8'h01);
    tick();
    chk("setwin_intr_hold", 64'(INTR), 64'h1);

    // Strobe and IRQ source held across reset release
    PORT_ID  = 8'h80;
    OUT_PORT = 8'h5A;
    IO_STRB  = 1'b1;
    IRQ_SRC  = 4'b1111;
    RST_N    = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    tick();
    chk("rst2_out_regs", OUT_REGS, 64'h0);
    chk("rst2_pulse", 64'(WR_PULSE), 64'h0);
    chk("rst2_intr", 64'(INTR), 64'h0);
    IO_STRB = 1'b0;
    tick();
    IO_STRB = 1'b1;
    tick();
    chk("rst2_retoggle_reg0", 64'(OUT_REGS[7:0]), 64'h5A);
    chk("rst2_retoggle_pulse", 64'(WR_PULSE), 64'h01);
    IO_STRB = 1'b0;
    tick();
    port_wr(8'hF1, 8'h0F);
    tick();
    tick();
    chk("rst2_no_pend_intr", 64'(INTR), 64'h0);
    rd("rst2_no_pend_stat", 8'hF0, 8'h00);
    rd("rst2_mask", 8'hF1, 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
